// File: rtl/maxpool2x2_layer2.sv
`default_nettype none
// ============================================================================
// Module   : maxpool2x2_layer2
// Purpose  : Streaming 2x2 / stride-2 signed max-pool over 16 parallel channels.
// Revision : 1.0
// ============================================================================
module maxpool2x2_layer2 #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int CH    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data0,  input  logic [7:0] in_data1,
  input  logic [7:0] in_data2,  input  logic [7:0] in_data3,
  input  logic [7:0] in_data4,  input  logic [7:0] in_data5,
  input  logic [7:0] in_data6,  input  logic [7:0] in_data7,
  input  logic [7:0] in_data8,  input  logic [7:0] in_data9,
  input  logic [7:0] in_data10, input  logic [7:0] in_data11,
  input  logic [7:0] in_data12, input  logic [7:0] in_data13,
  input  logic [7:0] in_data14, input  logic [7:0] in_data15,
  output logic       out_valid,
  output logic [7:0] out_pool0,  output logic [7:0] out_pool1,
  output logic [7:0] out_pool2,  output logic [7:0] out_pool3,
  output logic [7:0] out_pool4,  output logic [7:0] out_pool5,
  output logic [7:0] out_pool6,  output logic [7:0] out_pool7,
  output logic [7:0] out_pool8,  output logic [7:0] out_pool9,
  output logic [7:0] out_pool10, output logic [7:0] out_pool11,
  output logic [7:0] out_pool12, output logic [7:0] out_pool13,
  output logic [7:0] out_pool14, output logic [7:0] out_pool15,
  output logic       out_last
);

  localparam int c_nport  = 16;
  localparam int c_half_w = IMG_W / 2;
  localparam int c_half_h = IMG_H / 2;
  localparam int c_col_w  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int c_row_w  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int c_addr_w = (c_half_w > 1) ? $clog2(c_half_w) : 1;
  localparam int c_buf_w  = CH * 8;
  localparam logic [c_col_w-1:0] c_col_max  = c_col_w'(IMG_W - 1);
  localparam logic [c_row_w-1:0] c_row_max  = c_row_w'(IMG_H - 1);
  localparam logic [c_col_w-1:0] c_last_col = c_col_w'(2 * c_half_w - 1);
  localparam logic [c_row_w-1:0] c_last_row = c_row_w'(2 * c_half_h - 1);

  logic [c_col_w-1:0]  r_col_cnt;
  logic [c_row_w-1:0]  r_row_cnt;
  logic [7:0]          r_hold [c_nport];
  logic [7:0]          r_pool [c_nport];
  logic                r_valid;
  logic                r_last;
  logic [c_buf_w-1:0]  r_buf [c_half_w];

  logic [7:0]          w_in   [c_nport];
  logic [7:0]          w_max2 [c_nport];
  logic [7:0]          w_max3 [c_nport];
  logic [c_buf_w-1:0]  w_buf_rd;
  logic [c_buf_w-1:0]  w_buf_wr;
  logic [c_addr_w-1:0] w_addr;
  logic                w_col_last;
  logic                w_row_last;
  logic                w_wr;
  logic                w_emit;
  logic                w_last;

  assign w_in[0]  = in_data0;  assign w_in[1]  = in_data1;
  assign w_in[2]  = in_data2;  assign w_in[3]  = in_data3;
  assign w_in[4]  = in_data4;  assign w_in[5]  = in_data5;
  assign w_in[6]  = in_data6;  assign w_in[7]  = in_data7;
  assign w_in[8]  = in_data8;  assign w_in[9]  = in_data9;
  assign w_in[10] = in_data10; assign w_in[11] = in_data11;
  assign w_in[12] = in_data12; assign w_in[13] = in_data13;
  assign w_in[14] = in_data14; assign w_in[15] = in_data15;

  assign out_pool0  = r_pool[0];  assign out_pool1  = r_pool[1];
  assign out_pool2  = r_pool[2];  assign out_pool3  = r_pool[3];
  assign out_pool4  = r_pool[4];  assign out_pool5  = r_pool[5];
  assign out_pool6  = r_pool[6];  assign out_pool7  = r_pool[7];
  assign out_pool8  = r_pool[8];  assign out_pool9  = r_pool[9];
  assign out_pool10 = r_pool[10]; assign out_pool11 = r_pool[11];
  assign out_pool12 = r_pool[12]; assign out_pool13 = r_pool[13];
  assign out_pool14 = r_pool[14]; assign out_pool15 = r_pool[15];
  assign out_valid  = r_valid;
  assign out_last   = r_last;

  // Even rows only write the buffer and odd rows only read it, so one port pair never collides.
  assign w_addr     = c_addr_w'(r_col_cnt >> 1);
  assign w_buf_rd   = r_buf[w_addr];
  assign w_col_last = (r_col_cnt == c_col_max);
  assign w_row_last = (r_row_cnt == c_row_max);
  assign w_wr       = in_valid & ~r_row_cnt[0] & r_col_cnt[0];
  assign w_emit     = in_valid &  r_row_cnt[0] & r_col_cnt[0];
  assign w_last     = (r_row_cnt == c_last_row) && (r_col_cnt == c_last_col);

  generate
    for (genvar k = 0; k < c_nport; k++) begin : g_ch
      logic [7:0] w_above;
      assign w_max2[k] = ($signed(r_hold[k]) > $signed(w_in[k])) ? r_hold[k] : w_in[k];
      if (k < CH) begin : g_buf
        assign w_above                = w_buf_rd[8*k +: 8];
        assign w_buf_wr[8*k +: 8]     = w_max2[k];
      end else begin : g_nobuf
        assign w_above = 8'h80;
      end
      assign w_max3[k] = ($signed(w_max2[k]) > $signed(w_above)) ? w_max2[k] : w_above;
    end
    if (CH > c_nport) begin : g_pad
      assign w_buf_wr[c_buf_w-1:8*c_nport] = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_buf[w_addr] <= w_buf_wr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col_cnt <= '0;
      r_row_cnt <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      for (int i = 0; i < c_nport; i++) begin
        r_hold[i] <= '0;
        r_pool[i] <= '0;
      end
    end else begin
      r_valid <= w_emit;
      r_last  <= w_emit & w_last;
      if (in_valid) begin
        if (w_col_last) begin
          r_col_cnt <= '0;
          r_row_cnt <= w_row_last ? '0 : r_row_cnt + 1'b1;
        end else begin
          r_col_cnt <= r_col_cnt + 1'b1;
        end
        for (int i = 0; i < c_nport; i++) begin
          if (!r_col_cnt[0]) r_hold[i] <= w_in[i];
          if (w_emit)        r_pool[i] <= w_max3[i];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_maxpool2x2_layer2.sv
`default_nettype none
// Scoreboard bench for maxpool2x2_layer2: expected windows are computed from a
// stored frame image when the bottom-right pixel is driven.
module tb_maxpool2x2_layer2;

  localparam int W = 28;
  localparam int H = 28;

  typedef struct packed {
    logic [127:0] p;
    logic         last;
    logic [31:0]  due;
  } exp_t;

  logic       clk, rst, in_valid;
  logic [7:0] din [16];
  logic       out_valid, out_last;
  logic [7:0] dout [16];
  logic [127:0] pool_flat;

  logic [7:0] img [H][W][16];
  exp_t       sb [$];
  logic [127:0] out_log [400];
  logic [127:0] prev_pool;
  int   log_n, pulse_cnt, last_cnt;
  int   n_checks, n_errors;
  int   cyc;
  bit   mon_en;

  maxpool2x2_layer2 #(.IMG_W(W), .IMG_H(H), .CH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_data0(din[0]),   .in_data1(din[1]),   .in_data2(din[2]),   .in_data3(din[3]),
    .in_data4(din[4]),   .in_data5(din[5]),   .in_data6(din[6]),   .in_data7(din[7]),
    .in_data8(din[8]),   .in_data9(din[9]),   .in_data10(din[10]), .in_data11(din[11]),
    .in_data12(din[12]), .in_data13(din[13]), .in_data14(din[14]), .in_data15(din[15]),
    .out_valid(out_valid),
    .out_pool0(dout[0]),   .out_pool1(dout[1]),   .out_pool2(dout[2]),   .out_pool3(dout[3]),
    .out_pool4(dout[4]),   .out_pool5(dout[5]),   .out_pool6(dout[6]),   .out_pool7(dout[7]),
    .out_pool8(dout[8]),   .out_pool9(dout[9]),   .out_pool10(dout[10]), .out_pool11(dout[11]),
    .out_pool12(dout[12]), .out_pool13(dout[13]), .out_pool14(dout[14]), .out_pool15(dout[15]),
    .out_last(out_last)
  );

  always_comb begin
    pool_flat = '0;
    for (int k = 0; k < 16; k++) pool_flat[8*k +: 8] = dout[k];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] smax(input logic [7:0] a, input logic [7:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  // Monitor: every pulse must match the oldest expectation, exactly one cycle after its pixel.
  always @(negedge clk) begin
    if (rst) begin
      prev_pool = '0;
    end else if (mon_en) begin
      if (out_valid) begin
        exp_t e;
        pulse_cnt++;
        if (out_last) last_cnt++;
        if (log_n < 400) out_log[log_n] = pool_flat;
        log_n++;
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_pulse cyc=%0d got=%h", cyc, pool_flat);
        end else begin
          e = sb.pop_front();
          n_checks++;
          if (cyc !== int'(e.due)) begin
            n_errors++;
            $display("FAIL pulse_timing got_cyc=%0d expected_cyc=%0d", cyc, e.due);
          end
          n_checks++;
          if (pool_flat !== e.p) begin
            n_errors++;
            $display("FAIL pool_data got=%h expected=%h", pool_flat, e.p);
          end
          n_checks++;
          if (out_last !== e.last) begin
            n_errors++;
            $display("FAIL out_last got=%b expected=%b", out_last, e.last);
          end
        end
        prev_pool = pool_flat;
      end else begin
        n_checks++;
        if (pool_flat !== prev_pool) begin
          n_errors++;
          $display("FAIL pool_hold got=%h expected=%h", pool_flat, prev_pool);
        end
        if (sb.size() > 0 && int'(sb[0].due) < cyc) begin
          n_checks++;
          n_errors++;
          $display("FAIL missing_pulse expected_cyc=%0d now=%0d", sb[0].due, cyc);
          void'(sb.pop_front());
        end
      end
    end
  end

  // mode 0 ramp, 1 signed corner windows, 2 per-channel peaks, 3 random
  task automatic gen_img(input int mode);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        for (int n = 0; n < 16; n++) begin
          if (mode == 0) img[r][c][n] = 8'((r*W + c + n) % 128);
          else if (mode == 2) img[r][c][n] = 8'($urandom_range(0, 178) - 128);
          else img[r][c][n] = 8'($urandom_range(0, 255));
        end
    if (mode == 1) begin
      for (int n = 0; n < 16; n++) begin
        img[0][0][n] = 8'h80; img[0][1][n] = 8'hFB; img[1][0][n] = 8'hFF; img[1][1][n] = 8'h9C;
        img[0][2][n] = 8'h80; img[0][3][n] = 8'h80; img[1][2][n] = 8'h80; img[1][3][n] = 8'h80;
        img[0][4][n] = 8'h7F; img[0][5][n] = 8'h80; img[1][4][n] = 8'h00; img[1][5][n] = 8'h00;
      end
    end
    if (mode == 2) begin
      for (int wr = 0; wr < H/2; wr++)
        for (int wc = 0; wc < W/2; wc++)
          for (int k = 0; k < 16; k++) begin
            int pos;
            pos = k % 4;
            img[2*wr + pos/2][2*wc + pos%2][k] =
              (wr == 0 && wc == 0) ? 8'(100 + k) : 8'($urandom_range(51, 127));
          end
    end
  endtask

  task automatic drive_frame(input int duty, input int stop_r, input int stop_c);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        while ($urandom_range(0, 99) >= duty) begin
          @(posedge clk); #1;
          in_valid = 1'b0;
        end
        @(posedge clk); #1;
        in_valid = 1'b1;
        for (int n = 0; n < 16; n++) din[n] = img[r][c][n];
        if (r[0] && c[0]) begin
          exp_t e;
          e.p = '0;
          for (int n = 0; n < 16; n++)
            e.p[8*n +: 8] = smax(smax(img[r-1][c-1][n], img[r-1][c][n]),
                                 smax(img[r][c-1][n], img[r][c][n]));
          e.last = (r == H-1) && (c == W-1);
          e.due  = 32'(cyc + 1);
          sb.push_back(e);
        end
        if (r == stop_r && c == stop_c) return;
      end
  endtask

  task automatic drain();
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain_empty pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic clear_counts();
    pulse_cnt = 0; last_cnt = 0; log_n = 0;
  endtask

  task automatic check_counts(input string name, input int pulses, input int lasts);
    n_checks++;
    if (pulse_cnt !== pulses) begin
      n_errors++;
      $display("FAIL %s_pulses got=%0d expected=%0d", name, pulse_cnt, pulses);
    end
    n_checks++;
    if (last_cnt !== lasts) begin
      n_errors++;
      $display("FAIL %s_lasts got=%0d expected=%0d", name, last_cnt, lasts);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0;
    for (int n = 0; n < 16; n++) din[n] = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || pool_flat !== 128'h0) begin
      n_errors++;
      $display("FAIL reset_state got v=%b l=%b p=%h expected 0", out_valid, out_last, pool_flat);
    end
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_ramp();
    clear_counts();
    gen_img(0);
    drive_frame(100, -1, -1);
    drain();
    check_counts("ramp", 196, 1);
    n_checks++;
    if (out_log[0][7:0] !== 8'd29 || out_log[0][47:40] !== 8'd34) begin
      n_errors++;
      $display("FAIL ramp_first got ch0=%0d ch5=%0d expected ch0=29 ch5=34",
               out_log[0][7:0], out_log[0][47:40]);
    end
  endtask

  task automatic test_signed();
    clear_counts();
    gen_img(1);
    drive_frame(100, -1, -1);
    drain();
    check_counts("signed", 196, 1);
    n_checks++;
    if (out_log[0] !== {16{8'hFF}}) begin
      n_errors++;
      $display("FAIL signed_mixed got=%h expected=%h", out_log[0], {16{8'hFF}});
    end
    n_checks++;
    if (out_log[1] !== {16{8'h80}}) begin
      n_errors++;
      $display("FAIL signed_allmin got=%h expected=%h", out_log[1], {16{8'h80}});
    end
    n_checks++;
    if (out_log[2] !== {16{8'h7F}}) begin
      n_errors++;
      $display("FAIL signed_max got=%h expected=%h", out_log[2], {16{8'h7F}});
    end
  endtask

  task automatic test_channels();
    clear_counts();
    gen_img(2);
    drive_frame(100, -1, -1);
    drain();
    check_counts("chan", 196, 1);
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (out_log[0][8*k +: 8] !== 8'(100 + k)) begin
        n_errors++;
        $display("FAIL chan_peak ch=%0d got=%0d expected=%0d", k, out_log[0][8*k +: 8], 100 + k);
      end
    end
  endtask

  task automatic test_bursty();
    clear_counts();
    gen_img(0);
    drive_frame(40, -1, -1);
    drain();
    check_counts("bursty", 196, 1);
    n_checks++;
    if (out_log[0][7:0] !== 8'd29 || out_log[0][47:40] !== 8'd34) begin
      n_errors++;
      $display("FAIL bursty_first got ch0=%0d ch5=%0d expected ch0=29 ch5=34",
               out_log[0][7:0], out_log[0][47:40]);
    end
  endtask

  task automatic test_back_to_back();
    clear_counts();
    gen_img(0);
    drive_frame(100, -1, -1);
    gen_img(3);
    drive_frame(100, -1, -1);
    drain();
    check_counts("b2b", 392, 2);
  endtask

  task automatic test_reset_midframe();
    clear_counts();
    gen_img(0);
    drive_frame(100, 13, 7);
    #3;
    rst = 1'b1;
    in_valid = 1'b0;
    mon_en = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || pool_flat !== 128'h0) begin
      n_errors++;
      $display("FAIL midreset_async got v=%b l=%b p=%h expected 0", out_valid, out_last, pool_flat);
    end
    sb.delete();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    mon_en = 1'b1;
    clear_counts();
    gen_img(3);
    drive_frame(100, -1, -1);
    drain();
    check_counts("midreset", 196, 1);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; mon_en = 1'b0;
    prev_pool = '0;
    clear_counts();
    test_reset();
    test_ramp();
    test_signed();
    test_channels();
    test_bursty();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/maxpool2x2_layer2.md
Name: maxpool2x2_layer2

Overview:
Streaming 2x2 / stride-2 max-pooling stage that sits directly downstream of the 16-channel layer-2 convolution + SELU stage. It consumes that stage's raster-order 8-bit signed outputs, one pixel per in_valid and 16 channels in parallel. It produces one pooled pixel per 2x2 window (28x28 -> 14x14 by default) for the next conv/flatten stage. There is no backpressure, because upstream has no ready signal.

Parameters:
IMG_W, 28, input frame width in pixels (valid pixels only, no padding)
IMG_H, 28, input frame height in pixels
CH, 16, channel count; the ports are fixed at 16, and CH exists only for the buffer-width computation

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  qualifies in_data0..15 for one pixel
in_data0 .. in_data15  input  8 each  signed SELU outputs, channel n on in_data<n>
out_valid  output  1  one-cycle pulse per pooled pixel
out_pool0 .. out_pool15  output  8 each  signed pooled result, channel n
out_last  output  1  high together with out_valid on the final pooled pixel of a frame

Behaviour:
- Reset (rst=1, asynchronous, takes effect without a clock edge):
  - col_cnt, row_cnt, the half-row buffer write state and the even-column hold register all clear.
  - out_valid=0, out_last=0, out_pool0..15=0.
  - Buffer RAM contents need not clear; they are overwritten before use.
- Counters:
  - col_cnt runs 0..IMG_W-1 and row_cnt runs 0..IMG_H-1. Both advance only on in_valid.
  - col wraps to 0 and row increments; at row IMG_H-1, col IMG_W-1, both wrap to 0 and a new frame starts.
  - Idle cycles (in_valid=0) hold all state. Gaps of any length between pixels are legal.
- Comparison: signed 8-bit max, per channel independently. -128 is the smallest value; there is no saturation or rescaling.
- Even row (row_cnt[0]==0):
  - Even col: capture the pixel into the hold register h.
  - Odd col: write max(h, in) into half-row buffer entry col_cnt>>1.
  - The buffer is IMG_W/2 entries of CH*8 bits.
- Odd row (row_cnt[0]==1):
  - Even col: capture into h.
  - Odd col: compute max(h, in, buf[col_cnt>>1]) and register it onto out_pool*.
  - Assert out_valid for exactly one cycle.
- Latency: out_valid rises on the clock edge after the edge that samples the bottom-right pixel of the window (1 cycle).
- Outputs between pulses: out_pool* hold their last value while out_valid=0.
- out_last: asserted with out_valid when the emitting pixel is at row_cnt==IMG_H-1 (rounded down to an odd row) and col_cnt is the last odd column.
- Odd dimensions: with odd IMG_W or IMG_H, the trailing column or row is consumed by the counters but never contributes to a pooled output (floor behaviour).
  - Output size is (IMG_W/2) x (IMG_H/2); integer division.
- Throughput: sustains in_valid=1 every cycle indefinitely.
  - A buffer read and write never target the same entry in the same cycle, because writes occur only on even rows and reads only on odd rows.
- Mid-frame reset: the partial frame is discarded and no out_valid is produced for it. The first pixel after rst deasserts is treated as row 0, col 0.
- Output count per frame: exactly (IMG_W/2)*(IMG_H/2) out_valid pulses, the last carrying out_last.

Test Plan:
1. Ramp frame: channel n pixel = (row*28+col+n) mod 128, continuous in_valid. Required response:
   - 196 pulses per frame.
   - First pulse (window rows 0-1, cols 0-1) gives out_pool0=29, out_pool5=34.
   - out_valid is seen 1 cycle after pixel (1,1) is sampled.
   - out_last only on pulse 196.
2. Signed values: window {-128, -5, -1, -100} on all channels -> -1 (0xFF). Window of all -128 -> 0x80. Window {127, -128, 0, 0} -> 127.
3. Channel independence: max value at a different window position per channel (ch k peak at position k mod 4). Each out_pool<k> must equal its own peak, with no cross-channel mixing.
4. Bursty input: in_valid at random ~40% duty over the ramp frame. Outputs must be identical to scenario 1 in value, order and out_last. Every pulse must fall 1 cycle after the qualifying in_valid.
5. Back-to-back frames: two frames with no gap. 392 pulses total, out_last on pulses 196 and 392, and frame 2 results are uncorrupted by frame 1 buffer contents.
6. Reset mid-frame: assert rst asynchronously (off clock edge) at row 13, col 7. Required response:
   - out_valid=0 and out_pool*=0 immediately.
   - After release, a fresh full frame yields exactly 196 correct pulses.
